// File: rtl/priority_router.sv
// -----------------------------------------------------------------------------
// priority_router
//
// Version-selecting read mux for a multi-version data store. Each of the
// VERSION_NUM storage slots presents a data word, a version tag and a live bit.
// For a lookup at readVersion, the slot returned is the live slot with the
// newest version that is not newer than readVersion. When several slots have
// that same version, the lowest index wins. The result is registered, so a
// request sampled at one rising edge is answered on the outputs after that
// edge. A new request can be accepted on every cycle.
//
// Handshake: readValid qualifies the inputs sampled at a rising edge. outValid
// is high for exactly the cycle after each accepted request. There is no ready
// signal, because the block can always accept a request.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; all outputs are forced to 0
//   readValid    lookup request this cycle
//   readVersion  version being read (unsigned)
//   entryValid   bit i set = slot i holds live data
//   versions     slot i tag at  [i*VERSION_WIDTH +: VERSION_WIDTH]
//   dataInputs   slot i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   dataOut      selected data word (registered, 0 on miss)
//   outValid     result for the request of the previous cycle
//   hit          a qualifying slot was found
//   hitIndex     index of the selected slot (0 on miss)
// -----------------------------------------------------------------------------
module priority_router #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4,
  localparam int INDEX_WIDTH  = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 readValid,
  input  logic [VERSION_WIDTH-1:0]             readVersion,
  input  logic [VERSION_NUM-1:0]               entryValid,
  input  logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
  input  logic [DATA_WIDTH*VERSION_NUM-1:0]    dataInputs,
  output logic [DATA_WIDTH-1:0]                dataOut,
  output logic                                 outValid,
  output logic                                 hit,
  output logic [INDEX_WIDTH-1:0]               hitIndex
);

  // Per-slot views of the flattened input buses.
  logic [VERSION_WIDTH-1:0] slot_version [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    slot_data    [VERSION_NUM];
  logic [VERSION_NUM-1:0]   qualify;

  always_comb begin
    for (int i = 0; i < VERSION_NUM; i++) begin
      slot_version[i] = versions[i*VERSION_WIDTH +: VERSION_WIDTH];
      slot_data[i]    = dataInputs[i*DATA_WIDTH +: DATA_WIDTH];
      // The comparison is a plain unsigned one. A small readVersion never
      // wraps around to match large tags.
      qualify[i]      = entryValid[i] && (slot_version[i] <= readVersion);
    end
  end

  // Winner search. A later slot only replaces the current best candidate when
  // its version is strictly greater. This strict test is what makes the lowest
  // index win a tie. The winning data is carried along in the same scan, so it
  // never has to be indexed back out of the array. When no slot qualifies,
  // every winner signal stays 0. That is exactly the value a miss must present.
  logic                     win_found;
  logic [VERSION_WIDTH-1:0] win_version;
  logic [INDEX_WIDTH-1:0]   win_index;
  logic [DATA_WIDTH-1:0]    win_data;

  always_comb begin
    win_found   = 1'b0;
    win_version = '0;
    win_index   = '0;
    win_data    = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      if (qualify[i] && (!win_found || (slot_version[i] > win_version))) begin
        win_found   = 1'b1;
        win_version = slot_version[i];
        win_index   = INDEX_WIDTH'(i);
        win_data    = slot_data[i];
      end
    end
  end

  // Output register. An idle cycle clears outValid and hit. On an idle cycle,
  // dataOut and hitIndex keep the last answer, so a consumer that samples late
  // still sees stable data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut  <= '0;
      outValid <= 1'b0;
      hit      <= 1'b0;
      hitIndex <= '0;
    end else begin
      outValid <= readValid;
      if (readValid) begin
        hit      <= win_found;
        hitIndex <= win_index;
        dataOut  <= win_data;
      end else begin
        hit      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_router.sv
// -----------------------------------------------------------------------------
// tb_priority_router
//
// Directed bench for priority_router with the default parameters
// (32-bit data, 4-bit versions, 4 slots). Inputs are driven one time unit
// after a rising edge. Outputs are sampled one time unit after the next
// rising edge. The 20-cycle back-to-back run takes its expected results from a
// reference model. That model scans downward from readVersion and returns the
// first live slot whose tag equals the version being tried, taking the lowest
// index first.
// -----------------------------------------------------------------------------
module tb_priority_router;

  localparam int DW = 32;
  localparam int VW = 4;
  localparam int VN = 4;
  localparam int IW = 2;

  localparam logic [DW-1:0] A0 = 32'hA0A0_0001;
  localparam logic [DW-1:0] A1 = 32'hA1A1_0002;
  localparam logic [DW-1:0] A2 = 32'hA2A2_0003;
  localparam logic [DW-1:0] A3 = 32'hA3A3_0004;

  // ---------------------------------------------------------------- clock/reset
  logic            clk;
  logic            rst_n;
  logic            readValid;
  logic [VW-1:0]   readVersion;
  logic [VN-1:0]   entryValid;
  logic [VW*VN-1:0] versions;
  logic [DW*VN-1:0] dataInputs;
  logic [DW-1:0]   dataOut;
  logic            outValid;
  logic            hit;
  logic [IW-1:0]   hitIndex;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  priority_router #(
    .DATA_WIDTH    (DW),
    .VERSION_WIDTH (VW),
    .VERSION_NUM   (VN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .readValid   (readValid),
    .readVersion (readVersion),
    .entryValid  (entryValid),
    .versions    (versions),
    .dataInputs  (dataInputs),
    .dataOut     (dataOut),
    .outValid    (outValid),
    .hit         (hit),
    .hitIndex    (hitIndex)
  );

  // ---------------------------------------------------------------- scoreboard
  int vec_count  = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];
  logic [IW-1:0] exp_idx_q[$];
  logic          exp_hit_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ov, input logic h,
                               input logic [IW-1:0] idx, input logic [DW-1:0] d);
    check({tag, ".outValid"}, 64'(outValid), 64'(ov));
    check({tag, ".hit"},      64'(hit),      64'(h));
    check({tag, ".hitIndex"}, 64'(hitIndex), 64'(idx));
    check({tag, ".dataOut"},  64'(dataOut),  64'(d));
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slots(input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                           input logic [VW-1:0] v2, input logic [VW-1:0] v3);
    versions   = {v3, v2, v1, v0};
    dataInputs = {A3, A2, A1, A0};
  endtask

  task automatic request(input logic [VW-1:0] rv, input logic [VN-1:0] ev);
    readValid   = 1'b1;
    readVersion = rv;
    entryValid  = ev;
  endtask

  // Reference model: try each version from readVersion down to 0. For each
  // version, take the lowest-index live slot that carries exactly that tag.
  task automatic model(input logic [VW-1:0] rv, input logic [VN-1:0] ev,
                       input logic [VW*VN-1:0] vs, input logic [DW*VN-1:0] ds,
                       output logic h, output logic [IW-1:0] idx,
                       output logic [DW-1:0] d);
    h = 1'b0;
    idx = '0;
    d = '0;
    for (int v = int'(rv); v >= 0 && !h; v--) begin
      for (int i = 0; i < VN && !h; i++) begin
        if (ev[i] && (int'(vs[i*VW +: VW]) == v)) begin
          h   = 1'b1;
          idx = IW'(i);
          d   = ds[i*DW +: DW];
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic          m_hit;
    logic [IW-1:0] m_idx;
    logic [DW-1:0] m_data;
    logic [DW-1:0] last_data;
    logic [IW-1:0] last_idx;

    // Reset held low while a request with live data is presented.
    rst_n = 1'b0;
    set_slots(4'd3, 4'd7, 4'd2, 4'd5);
    request(4'd6, 4'hF);
    repeat (2) tick();
    check_outputs("reset_hold", 1'b0, 1'b0, 2'd0, '0);
    rst_n = 1'b1;

    // Basic select: the best candidate at or below 6 is version 5, in slot 3.
    tick();
    check_outputs("basic", 1'b1, 1'b1, 2'd3, A3);

    // Tie and exact match.
    set_slots(4'd5, 4'd5, 4'd9, 4'd1);
    request(4'd5, 4'hF);
    tick();
    check_outputs("tie_exact", 1'b1, 1'b1, 2'd0, A0);
    request(4'd15, 4'hF);
    tick();
    check_outputs("all_ones", 1'b1, 1'b1, 2'd2, A2);

    // Miss: every tag is newer than the read version.
    set_slots(4'd8, 4'd9, 4'd10, 4'd11);
    request(4'd4, 4'hF);
    tick();
    check_outputs("miss", 1'b1, 1'b0, 2'd0, '0);

    // Masking: slot 3 is dead, so version 7 in slot 1 wins.
    set_slots(4'd3, 4'd7, 4'd2, 4'd5);
    request(4'd15, 4'b0111);
    tick();
    check_outputs("mask", 1'b1, 1'b1, 2'd1, A1);

    // Idle cycle: valid and hit drop, while data and index hold.
    readValid = 1'b0;
    set_slots(4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    check_outputs("idle_hold", 1'b0, 1'b0, 2'd1, A1);

    // readVersion=0: only version-0 slots (1 and 3) match, and the lower index wins.
    set_slots(4'd4, 4'd0, 4'd3, 4'd0);
    request(4'd0, 4'hF);
    tick();
    check_outputs("rv_zero", 1'b1, 1'b1, 2'd1, A1);

    // No live entries.
    set_slots(4'd1, 4'd2, 4'd3, 4'd4);
    request(4'd15, 4'h0);
    tick();
    check_outputs("ev_zero", 1'b1, 1'b0, 2'd0, '0);

    // Inputs that change between edges leave the registered answer unchanged.
    set_slots(4'd3, 4'd7, 4'd2, 4'd5);
    request(4'd6, 4'hF);
    tick();
    #2;
    request(4'd0, 4'h0);
    #0;
    check_outputs("mid_change", 1'b1, 1'b1, 2'd3, A3);

    // Reset asserted mid-cycle clears the outputs without any clock edge.
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 1'b0, 2'd0, '0);
    readValid = 1'b0;
    rst_n = 1'b1;
    tick();
    check_outputs("post_rst_idle", 1'b0, 1'b0, 2'd0, '0);
    set_slots(4'd3, 4'd7, 4'd2, 4'd5);
    request(4'd6, 4'hF);
    tick();
    check_outputs("post_rst_req", 1'b1, 1'b1, 2'd3, A3);

    // Back-to-back randomized requests checked against the reference model.
    for (int n = 0; n < 20; n++) begin
      readValid   = 1'b1;
      readVersion = VW'($urandom_range(0, 15));
      entryValid  = VN'($urandom_range(0, 15));
      for (int i = 0; i < VN; i++) begin
        versions[i*VW +: VW]   = VW'($urandom_range(0, 15));
        dataInputs[i*DW +: DW] = $urandom();
      end
      model(readVersion, entryValid, versions, dataInputs, m_hit, m_idx, m_data);
      exp_q.push_back(m_data);
      exp_idx_q.push_back(m_idx);
      exp_hit_q.push_back(m_hit);
      tick();
      last_data = exp_q.pop_front();
      last_idx  = exp_idx_q.pop_front();
      check_outputs($sformatf("pipe%0d", n), 1'b1, exp_hit_q.pop_front(), last_idx, last_data);
    end

    // Dropping readValid after the stream keeps the last data and index.
    readValid = 1'b0;
    tick();
    check_outputs("pipe_drop", 1'b0, 1'b0, last_idx, last_data);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/priority_router.md
Name: priority_router

Overview:
- Version-selecting read mux for a multi-version data store.
- Takes VERSION_NUM candidate data words, each tagged with a version number, plus a read version.
- Returns the candidate with the newest version that is not newer than the read version.
- Sits between the per-version storage slots and the read port; one registered lookup per cycle.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- VERSION_WIDTH, 4, width of each version tag and of readVersion; unsigned.
- VERSION_NUM, 4, number of candidate slots; must be ≥1.
- INDEX_WIDTH, derived: max(1, clog2(VERSION_NUM)); not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- readValid  in  1  lookup request this cycle.
- readVersion  in  VERSION_WIDTH  version being read (unsigned).
- entryValid  in  VERSION_NUM  bit i set = slot i holds live data.
- versions  in  VERSION_WIDTH*VERSION_NUM  slot i tag at [i*VERSION_WIDTH +: VERSION_WIDTH].
- dataInputs  in  DATA_WIDTH*VERSION_NUM  slot i data at [i*DATA_WIDTH +: DATA_WIDTH].
- dataOut  out  DATA_WIDTH  selected data word (registered).
- outValid  out  1  result for the request of the previous cycle.
- hit  out  1  a qualifying slot was found.
- hitIndex  out  INDEX_WIDTH  index of the selected slot.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0, all outputs are forced low: dataOut=0, outValid=0, hit=0, hitIndex=0.
  - Deassertion takes effect at the next rising edge.
- Qualification: slot i qualifies iff entryValid[i]=1 AND versions[i] ≤ readVersion (unsigned compare, no wrap-around semantics).
- Winner selection:
  - Winner = qualifying slot with the largest version.
  - Tie on equal version: lowest index wins.
  - Selection is purely combinational from the current inputs.
- Latency: exactly 1 cycle. The result for inputs sampled at edge N appears on the outputs after edge N.
- At each rising edge with readValid=1:
  - outValid←1.
  - If a winner exists: hit←1, hitIndex←winner, dataOut←dataInputs[winner].
  - If no winner: hit←0, hitIndex←0, dataOut←0.
- At each rising edge with readValid=0: outValid←0, hit←0. dataOut and hitIndex hold their previous values.
- No backpressure: a new request is accepted every cycle. Back-to-back requests produce back-to-back results.
- Boundary cases:
  - readVersion=0 matches only slots with version 0.
  - readVersion=all-ones matches every valid slot.
  - entryValid=0 → miss.
  - Inputs changing between edges have no effect until sampled.
- Reset asserted mid-stream: the in-flight result is discarded and outputs clear immediately. The first result after release comes from the first edge with readValid=1.

Test Plan (defaults DW=32, VW=4, VN=4):
- Reset: hold rst_n=0 with readValid=1 and arbitrary inputs → all outputs 0. Assert rst_n asynchronously mid-cycle → outputs clear without waiting for a clock edge.
- Basic select: versions={3,7,2,5} (slots 0..3), data={A0,A1,A2,A3}, entryValid=4'hF, readVersion=6 → next cycle outValid=1, hit=1, hitIndex=3, dataOut=A3.
- Tie and exact match: versions={5,5,9,1}, readVersion=5 → hitIndex=0, dataOut=A0. Then readVersion=15 → hitIndex=2.
- Miss and entryValid masking:
  - versions={8,9,10,11}, readVersion=4 → hit=0, dataOut=0, outValid=1.
  - versions={3,7,2,5}, entryValid=4'b0111, readVersion=15 → hitIndex=1.
- Pipelining: 20 consecutive cycles with randomized readVersion, versions and data, readValid=1 → each cycle's outputs match a reference model of the previous cycle's inputs. Dropping readValid → outValid=0 and hit=0 on the next cycle, with dataOut held.
